// File: rtl/line_word_buffer.sv
// Cache line word buffer: holds one line filled from memory in multi-beat
// bursts and serves registered word reads / byte-masked word writes.
//
// Ports
//   clk, reset_n          clock (rising edge), async active-low reset
//   fill_start            begin a burst fill (discards the current line)
//   fill_valid/fill_data  next fill beat; word j at [j*WORD_WIDTH +: WORD_WIDTH]
//   fill_done             one-cycle pulse after the last beat is captured
//   line_valid            line fully filled
//   rd_req/rd_sel         read request (held until rd_ack) and word offset
//   rd_ack/rd_data        one-cycle ack with the registered read word
//   wr_en/wr_sel/wr_data/wr_mask  single-cycle byte-masked word write
//   clean                 clear dirty after write-back
//   dirty                 line modified since fill
//   line_out              whole line, word i at [i*WORD_WIDTH +: WORD_WIDTH]
module line_word_buffer #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned WORDS      = 16,
  parameter int unsigned BEAT_WORDS = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               fill_start,
  input  logic                               fill_valid,
  input  logic [BEAT_WORDS*WORD_WIDTH-1:0]   fill_data,
  output logic                               fill_done,
  output logic                               line_valid,
  input  logic                               rd_req,
  input  logic [$clog2(WORDS)-1:0]           rd_sel,
  output logic                               rd_ack,
  output logic [WORD_WIDTH-1:0]              rd_data,
  input  logic                               wr_en,
  input  logic [$clog2(WORDS)-1:0]           wr_sel,
  input  logic [WORD_WIDTH-1:0]              wr_data,
  input  logic [WORD_WIDTH/8-1:0]            wr_mask,
  input  logic                               clean,
  output logic                               dirty,
  output logic [WORDS*WORD_WIDTH-1:0]        line_out
);

  localparam int unsigned SEL_W  = $clog2(WORDS);
  localparam int unsigned BEATS  = WORDS / BEAT_WORDS;
  localparam int unsigned MASK_W = WORD_WIDTH / 8;
  localparam int unsigned BCW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFF_SH = $clog2(BEAT_WORDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_READY = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [BCW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [BEATS-1:0]      arrived_q, arrived_d;
  logic [WORD_WIDTH-1:0] words_q [WORDS];
  logic [WORD_WIDTH-1:0] words_d [WORDS];
  logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_ack_q, rd_ack_d;
  logic                  fill_done_q, fill_done_d;
  logic                  line_valid_q, line_valid_d;
  logic                  dirty_q, dirty_d;

  // Combinational helpers for the read path and fill sequencing
  logic [BCW-1:0]        rd_beat;
  logic [SEL_W-1:0]      rd_off;
  logic [WORD_WIDTH-1:0] bypass_word;
  logic                  fill_last;
  logic                  beat_hit;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      beat_cnt_q   <= '0;
      arrived_q    <= '0;
      rd_data_q    <= '0;
      rd_ack_q     <= 1'b0;
      fill_done_q  <= 1'b0;
      line_valid_q <= 1'b0;
      dirty_q      <= 1'b0;
      for (int i = 0; i < int'(WORDS); i++) begin
        words_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      arrived_q    <= arrived_d;
      rd_data_q    <= rd_data_d;
      rd_ack_q     <= rd_ack_d;
      fill_done_q  <= fill_done_d;
      line_valid_q <= line_valid_d;
      dirty_q      <= dirty_d;
      for (int i = 0; i < int'(WORDS); i++) begin
        words_q[i] <= words_d[i];
      end
    end
  end

  // Next-state, storage update and read serving
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    arrived_d    = arrived_q;
    rd_data_d    = rd_data_q;
    rd_ack_d     = 1'b0;
    fill_done_d  = 1'b0;
    line_valid_d = line_valid_q;
    dirty_d      = dirty_q;
    for (int i = 0; i < int'(WORDS); i++) begin
      words_d[i] = words_q[i];
    end

    rd_beat   = BCW'(rd_sel >> OFF_SH);
    rd_off    = rd_sel & SEL_W'(BEAT_WORDS - 1);
    fill_last = (beat_cnt_q == BCW'(BEATS - 1));
    beat_hit  = fill_valid && (beat_cnt_q == rd_beat);

    // Word of the beat on fill_data that rd_sel points at (fill bypass)
    bypass_word = '0;
    for (int j = 0; j < int'(BEAT_WORDS); j++) begin
      if (rd_off == SEL_W'(j)) begin
        bypass_word = fill_data[j*WORD_WIDTH +: WORD_WIDTH];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (fill_start) begin
          state_d    = S_FILL;
          beat_cnt_d = '0;
          arrived_d  = '0;
        end
      end

      S_FILL: begin
        // Critical-word read: stored beat, or the beat arriving right now
        if (rd_req) begin
          if (arrived_q[rd_beat]) begin
            rd_ack_d  = 1'b1;
            rd_data_d = words_q[rd_sel];
          end else if (beat_hit) begin
            rd_ack_d  = 1'b1;
            rd_data_d = bypass_word;
          end
        end
        if (fill_valid) begin
          for (int j = 0; j < int'(BEAT_WORDS); j++) begin
            words_d[SEL_W'(int'(beat_cnt_q) * int'(BEAT_WORDS) + j)] =
              fill_data[j*WORD_WIDTH +: WORD_WIDTH];
          end
          arrived_d[beat_cnt_q] = 1'b1;
          if (fill_last) begin
            state_d      = S_READY;
            beat_cnt_d   = '0;
            line_valid_d = 1'b1;
            fill_done_d  = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + BCW'(1);
          end
        end
      end

      S_READY: begin
        // Read sees pre-write storage, so same-word read returns old data
        if (rd_req) begin
          rd_ack_d  = 1'b1;
          rd_data_d = words_q[rd_sel];
        end
        if (fill_start) begin
          state_d      = S_FILL;
          beat_cnt_d   = '0;
          arrived_d    = '0;
          line_valid_d = 1'b0;
          dirty_d      = 1'b0;
        end else if (wr_en) begin
          for (int b = 0; b < int'(MASK_W); b++) begin
            if (wr_mask[b]) begin
              words_d[wr_sel][8*b +: 8] = wr_data[8*b +: 8];
            end
          end
          dirty_d = 1'b1;
        end else if (clean) begin
          dirty_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Flatten storage onto the line bus
  always_comb begin
    line_out = '0;
    for (int i = 0; i < int'(WORDS); i++) begin
      line_out[i*WORD_WIDTH +: WORD_WIDTH] = words_q[i];
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_ack     = rd_ack_q;
  assign fill_done  = fill_done_q;
  assign line_valid = line_valid_q;
  assign dirty      = dirty_q;

endmodule

// File: tb/tb_line_word_buffer.sv
// Bench for line_word_buffer: directed scenarios followed by random traffic,
// all compared cycle by cycle against a transaction-level line model.
module tb_line_word_buffer;

  localparam int unsigned WW     = 16;
  localparam int unsigned WORDS  = 16;
  localparam int unsigned BW     = 4;
  localparam int unsigned BEATS  = WORDS / BW;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned MASK_W = WW / 8;
  localparam int unsigned LINE_W = WORDS * WW;
  localparam int unsigned BEAT_W = BW * WW;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              fill_start, fill_valid;
  logic [BEAT_W-1:0] fill_data;
  logic              fill_done, line_valid;
  logic              rd_req;
  logic [SEL_W-1:0]  rd_sel;
  logic              rd_ack;
  logic [WW-1:0]     rd_data;
  logic              wr_en;
  logic [SEL_W-1:0]  wr_sel;
  logic [WW-1:0]     wr_data;
  logic [MASK_W-1:0] wr_mask;
  logic              clean;
  logic              dirty;
  logic [LINE_W-1:0] line_out;

  line_word_buffer #(.WORD_WIDTH(WW), .WORDS(WORDS), .BEAT_WORDS(BW)) dut (
    .clk(clk), .reset_n(reset_n),
    .fill_start(fill_start), .fill_valid(fill_valid), .fill_data(fill_data),
    .fill_done(fill_done), .line_valid(line_valid),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack), .rd_data(rd_data),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .wr_mask(wr_mask),
    .clean(clean), .dirty(dirty), .line_out(line_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: line contents plus "how many beats have landed"
  logic [WW-1:0] m_mem [WORDS];
  bit            m_filling, m_ready;
  int            m_got;
  bit            m_lv, m_dirty, m_ack, m_done;
  logic [WW-1:0] m_rdata;

  function automatic logic [WW-1:0] beat_word(input logic [BEAT_W-1:0] d, input int j);
    return d[j*WW +: WW];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(WORDS); i++) m_mem[i] = '0;
    m_filling = 0; m_ready = 0; m_got = 0;
    m_lv = 0; m_dirty = 0; m_ack = 0; m_done = 0; m_rdata = '0;
  endtask

  // Apply the current inputs for one clock edge
  task automatic model_edge();
    int rb;
    m_ack  = 0;
    m_done = 0;
    rb = int'(rd_sel) / int'(BW);
    if (m_ready) begin
      if (rd_req) begin m_ack = 1; m_rdata = m_mem[rd_sel]; end
      if (fill_start) begin
        m_ready = 0; m_filling = 1; m_got = 0; m_lv = 0; m_dirty = 0;
      end else if (wr_en) begin
        for (int b = 0; b < int'(MASK_W); b++)
          if (wr_mask[b]) m_mem[wr_sel][8*b +: 8] = wr_data[8*b +: 8];
        m_dirty = 1;
      end else if (clean) begin
        m_dirty = 0;
      end
    end else if (m_filling) begin
      if (rd_req) begin
        if (rb < m_got) begin m_ack = 1; m_rdata = m_mem[rd_sel]; end
        else if (fill_valid && rb == m_got) begin
          m_ack = 1; m_rdata = beat_word(fill_data, int'(rd_sel) % int'(BW));
        end
      end
      if (fill_valid) begin
        for (int j = 0; j < int'(BW); j++) m_mem[m_got*int'(BW) + j] = beat_word(fill_data, j);
        m_got++;
        if (m_got == int'(BEATS)) begin
          m_filling = 0; m_ready = 1; m_lv = 1; m_done = 1;
        end
      end
    end else if (fill_start) begin
      m_filling = 1; m_got = 0;
    end
  endtask

  function automatic logic [LINE_W-1:0] model_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < int'(WORDS); i++) l[i*WW +: WW] = m_mem[i];
    return l;
  endfunction

  task automatic check_all(input string ctx);
    check({ctx, ".rd_ack"}, LINE_W'(rd_ack), LINE_W'(m_ack));
    check({ctx, ".rd_data"}, LINE_W'(rd_data), LINE_W'(m_rdata));
    check({ctx, ".fill_done"}, LINE_W'(fill_done), LINE_W'(m_done));
    check({ctx, ".line_valid"}, LINE_W'(line_valid), LINE_W'(m_lv));
    check({ctx, ".dirty"}, LINE_W'(dirty), LINE_W'(m_dirty));
    check({ctx, ".line_out"}, line_out, model_line());
  endtask

  // One clock: model sees the same inputs as the DUT, then compare
  task automatic step(input string ctx);
    model_edge();
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic idle_inputs();
    fill_start = 0; fill_valid = 0; fill_data = '0;
    rd_req = 0; rd_sel = '0;
    wr_en = 0; wr_sel = '0; wr_data = '0; wr_mask = '0; clean = 0;
  endtask

  // Async reset between edges: outputs must clear without waiting for clk
  task automatic mid_cycle_reset(input string ctx);
    #2 reset_n = 0;
    #1;
    model_reset();
    check_all(ctx);
    @(negedge clk);
    reset_n = 1;
  endtask

  function automatic logic [BEAT_W-1:0] make_beat(input logic [WW-1:0] base);
    logic [BEAT_W-1:0] d;
    for (int j = 0; j < int'(BW); j++) d[j*WW +: WW] = base + WW'(j);
    return d;
  endfunction

  task automatic fill_beats(input logic [WW-1:0] base, input string ctx);
    for (int k = 0; k < int'(BEATS); k++) begin
      fill_valid = 1;
      fill_data  = make_beat(base + WW'(k * int'(BW)));
      step(ctx);
    end
    fill_valid = 0;
  endtask

  logic [LINE_W-1:0] ramp;

  initial begin
    idle_inputs();
    model_reset();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;

    // Initial fill: words 0..15 = 0x0000..0x000F
    fill_start = 1; step("fill_start"); fill_start = 0;
    fill_beats(16'h0000, "fill1");
    check("fill1.done_pulse", LINE_W'(fill_done), LINE_W'(1));
    for (int i = 0; i < int'(WORDS); i++) ramp[i*WW +: WW] = WW'(i);
    check("fill1.ramp", line_out, ramp);
    step("fill1.after");
    check("fill1.done_low", LINE_W'(fill_done), LINE_W'(0));

    // Single read then three back-to-back reads
    rd_req = 1; rd_sel = 9; step("rd9");
    check("rd9.data", LINE_W'(rd_data), LINE_W'(16'h0009));
    rd_sel = 10; step("rd10");
    rd_sel = 11; step("rd11");
    check("rd11.data", LINE_W'(rd_data), LINE_W'(16'h000B));
    rd_req = 0; step("rd_idle");

    // Refill with critical-word read of sel 13 pending before any beat
    fill_start = 1; rd_req = 1; rd_sel = 13; step("refill_start");
    fill_start = 0;
    fill_beats(16'h0100, "refill");
    check("refill.crit_ack", LINE_W'(rd_ack), LINE_W'(1));
    check("refill.crit_data", LINE_W'(rd_data), LINE_W'(16'h010D));
    rd_req = 0; step("refill.after");

    // Masked write with same-cycle read of the same word
    wr_en = 1; wr_sel = 2; wr_data = 16'hABCD; wr_mask = 2'b10;
    rd_req = 1; rd_sel = 2; step("wr2");
    check("wr2.old_data", LINE_W'(rd_data), LINE_W'(16'h0102));
    check("wr2.dirty", LINE_W'(dirty), LINE_W'(1));
    wr_en = 0; step("wr2.reread");
    check("wr2.new_data", LINE_W'(rd_data), LINE_W'(16'hAB02));
    rd_req = 0; step("wr2.idle");

    // Write during fill is dropped; clean plus write keeps dirty
    fill_start = 1; step("wfill_start"); fill_start = 0;
    wr_en = 1; wr_sel = 5; wr_data = 16'hFFFF; wr_mask = 2'b11; step("wfill.drop");
    wr_en = 0;
    check("wfill.dirty", LINE_W'(dirty), LINE_W'(0));
    fill_beats(16'h0200, "wfill");
    wr_en = 1; clean = 1; wr_sel = 0; wr_mask = 2'b00; step("clean_wr");
    check("clean_wr.dirty", LINE_W'(dirty), LINE_W'(1));
    wr_en = 0; step("clean_only");
    check("clean_only.dirty", LINE_W'(dirty), LINE_W'(0));
    clean = 0;

    // Reset in the middle of a fill with a read pending
    fill_start = 1; step("rst_fill_start"); fill_start = 0;
    for (int k = 0; k < 2; k++) begin
      fill_valid = 1; fill_data = make_beat(WW'(16'h0300 + k * int'(BW))); step("rst_fill");
    end
    fill_valid = 0; rd_req = 1; rd_sel = 13; step("rst_pending");
    mid_cycle_reset("rst_mid");
    for (int c = 0; c < 4; c++) step("post_rst_rd");
    rd_req = 0;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      fill_start = ($urandom_range(0, 19) == 0);
      fill_valid = $urandom_range(0, 1) == 1;
      fill_data  = {$urandom(), $urandom()};
      if (!rd_req || m_ack) begin
        rd_req = $urandom_range(0, 1) == 1;
        rd_sel = SEL_W'($urandom());
      end
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_sel  = SEL_W'($urandom());
      wr_data = WW'($urandom());
      wr_mask = MASK_W'($urandom());
      clean   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0) mid_cycle_reset("rand_rst");
      else step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/line_word_buffer.md
Name: line_word_buffer

Overview:
- Parametrised successor to the 16:1 word select used in the cache datapath.
- Holds one cache line, filled from memory in multi-beat bursts.
- Serves registered word reads by offset, including critical-word reads while a fill is still arriving.
- Merges byte-masked word writes and tracks dirty state. Sits between the memory-side burst port and the CPU-side word port.

Parameters:
- WORD_WIDTH, 16, bits per word; multiple of 8.
- WORDS, 16, words per line; power of 2, >= 2.
- BEAT_WORDS, 4, words per fill beat; power of 2, divides WORDS.
- Derived: SEL_W = $clog2(WORDS); BEATS = WORDS/BEAT_WORDS; MASK_W = WORD_WIDTH/8; LINE_W = WORDS*WORD_WIDTH.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- fill_start  in  1  begin burst fill; discards current line
- fill_valid  in  1  fill_data carries the next beat
- fill_data  in  BEAT_WORDS*WORD_WIDTH  beat payload; word j at [j*WORD_WIDTH +: WORD_WIDTH]
- fill_done  out  1  one-cycle pulse after the last beat is captured
- line_valid  out  1  line fully filled
- rd_req  in  1  read request; held until rd_ack
- rd_sel  in  SEL_W  word offset; stable while rd_req is high
- rd_ack  out  1  one-cycle pulse; rd_data valid this cycle
- rd_data  out  WORD_WIDTH  registered read word
- wr_en  in  1  word write, single cycle
- wr_sel  in  SEL_W  word offset
- wr_data  in  WORD_WIDTH  write word
- wr_mask  in  MASK_W  byte enables; bit b covers bits [8b +: 8]
- clean  in  1  clear dirty (write-back done)
- dirty  out  1  line modified since fill
- line_out  out  LINE_W  full line; word i at [i*WORD_WIDTH +: WORD_WIDTH]

Behaviour:
- Reset (async assert, sync release): state IDLE; line storage, rd_data, beat counter = 0; rd_ack, fill_done, line_valid, dirty = 0.
- States are IDLE, FILL and READY.
- IDLE: fill_start -> FILL. Beat counter = 0, arrived-beat vector = 0.
- FILL:
  - Each cycle with fill_valid high, beat beat_cnt is written to words beat_cnt*BEAT_WORDS..+BEAT_WORDS-1, its arrived bit is set, and beat_cnt increments.
  - On the last beat (beat_cnt = BEATS-1): next state READY, line_valid = 1, fill_done pulses the following cycle.
  - fill_start is ignored in FILL.
- READY: fill_start -> FILL, with line_valid = 0 and dirty = 0 the same edge. Stored words are not cleared.
- Read, 1-cycle latency:
  - Served when rd_req is high and either (READY) or (FILL and the arrived bit of beat rd_sel/BEAT_WORDS is set).
  - rd_data = word[rd_sel] and rd_ack = 1 on the next edge.
  - In FILL with the beat not yet arrived: stall, no ack.
  - Served on the cycle that beat is captured: rd_data = fill_data word, with ack the next edge (fill bypass).
  - After an ack, a still-high rd_req the next cycle is treated as a new request; ack again one cycle later. Back-to-back reads give one ack every cycle.
  - In IDLE, reads are never acked.
- Write:
  - Accepted only in READY with wr_en high. Byte b of word[wr_sel] updates where wr_mask[b] = 1.
  - dirty = 1 on the next edge, even if wr_mask = 0.
  - wr_en in IDLE/FILL is dropped; no state change.
- Same-cycle read and write to the same word: rd_data returns the pre-write value.
- clean together with an accepted write: dirty = 1; the write wins.
- fill_start together with a write in READY: the write is dropped and FILL is entered.
- line_out reflects storage directly, with no extra latency.
- Reset asserted mid-fill or mid-read: immediate return to the reset state. A pending rd_ack is suppressed.

Test Plan:
- Reset, then a 4-beat fill with beat k = {4{16'h(k*4+j)}} words 0..15 = 0x0000..0x000F -> fill_done pulses one cycle after beat 3; line_valid = 1; line_out word i = i.
- In READY, rd_req with rd_sel = 9 -> rd_ack next cycle, rd_data = 0x0009. Hold rd_req for 3 cycles on sel 9, 10, 11 -> acks on 3 consecutive cycles.
- fill_start, rd_req sel = 13 asserted before any beat -> no ack until beat 3 is captured; ack the following cycle with rd_data = fill word 1 of beat 3.
- READY, write sel = 2, data 0xABCD, mask 2'b10 over 0x0002 -> word2 = 0xAB02, dirty = 1. Same-cycle read sel 2 returns 0x0002; the next read returns 0xAB02.
- wr_en during FILL -> line unchanged, dirty = 0. clean with wr_en in READY -> dirty stays 1.
- reset_n low after beat 1 with rd_req pending -> all outputs 0 immediately, no ack. Post-reset rd_req is never acked until a new fill.
